matmul_sequencer: RTL
=====================

// Module: matmul_sequencer
// PURPOSE
//   Controller that computes C = A x B for NxN matrices held in the slave register bank, using one shared
//   multiply-accumulate. Reads A/B operands through two read ports, writes each C element back to the
//   bank's datain registers (which feed the HEX displays). Sits between the Avalon slave register bank
//   and the result registers inside the Matrix_new system.
// PARAMETERS
//   N   2                   matrix dimension (N >= 1)
//   DW  32                  operand/result width, signed two's complement
//   AW  $clog2(N*N) (min 1) element address width
// PORTS
//   clk      in   1   system clock
//   reset    in   1   asynchronous, active-high reset
//   start    in   1   begin multiply; sampled only in IDLE
//   abort    in   1   cancel current run; returns to IDLE next cycle
//   a_addr   out  AW  A element address, row-major: i*N+k
//   a_data   in   DW  A element, valid one cycle after a_addr
//   b_addr   out  AW  B element address, row-major: k*N+j
//   b_data   in   DW  B element, valid one cycle after b_addr
//   wr_en    out  1   one-cycle write strobe for C element
//   wr_addr  out  AW  C element address, row-major: i*N+j
//   wr_data  out  DW  C element value
//   busy     out  1   high in any state except IDLE and DONE
//   done     out  1   one-cycle pulse on completion
// BEHAVIOUR
// - Reset (async, any time): state=IDLE, i/j/k=0, acc=0. All outputs 0 (a_addr, b_addr, wr_en, wr_addr,
//   wr_data, busy, done). A reset mid-run produces no further writes.
// - FSM: IDLE -> CLEAR -> (FETCH -> ACC) x N -> WRITE -> CLEAR (next element) | DONE -> IDLE.
//   IDLE:  start=1 & abort=0 -> CLEAR with i=j=k=0. Otherwise stay.
//   CLEAR: acc<=0, k<=0.
//   FETCH: drive a_addr=i*N+k, b_addr=k*N+j.
//   ACC:   acc <= acc + a_data*b_data. Full 2*DW signed product; acc keeps the low DW bits (wraps, no
//          saturation). k==N-1 -> WRITE, else k++ -> FETCH.
//   WRITE: wr_en=1, wr_addr=i*N+j, wr_data=acc. Advance j; on j wrap advance i. Last element (i=j=N-1)
//          -> DONE, else -> CLEAR.
//   DONE:  done=1 for exactly one cycle -> IDLE.
// - a_addr/b_addr hold their last value outside FETCH/ACC. wr_en is 0 outside WRITE.
//   wr_addr/wr_data hold their last value.
// - Timing: start is sampled in IDLE at cycle 0. The C element with index e is written at cycle
//   (e+1)(2N+2). done is high at cycle 1 + N*N*(2N+2), i.e. cycle 25 for N=2.
// - start while busy or in DONE: ignored, never queued.
// - abort: any non-IDLE state -> IDLE next cycle. No further wr_en and no done. In WRITE, the current
//   write still completes that cycle. abort and start together in IDLE: abort wins.
// - Writes are issued in row-major order, one per element, no duplicates. Bank contents are assumed
//   static during a run; this block does not detect changes.
// TESTING
//   T1 N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse start -> writes (0,19),(1,22),(2,43),(3,50) in order;
//      done at cycle 25.
//   T2 A=I, B=[[9,-3],[0,7]] -> C equals B exactly. A=-I -> C=[[-9,3],[0,-7]] (0xFFFFFFF7, ...).
//   T3 Overflow: A=[[0x10000,0],[0,0]], B=[[0x10000,0],[0,0]] -> C[0]=0x00000000 (truncation);
//      0x7FFFFFFF+1 accumulation wraps to 0x80000000.
//   T4 Pulse start again at cycle 5 of a run -> ignored; exactly 4 writes and one done pulse.
//   T5 abort in ACC of element 2 -> IDLE next cycle; only elements 0,1 written; no done; a new start
//      then completes normally.
//   T6 reset asserted mid-run between clock edges -> outputs 0 immediately; after release, idle until
//      start.

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// Bus bundle between the matrix-multiply sequencer and the register bank / host.
// slave = sequencer side, master = bank/host side.
interface matmul_sequencer_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 2
);
    logic          start;
    logic          abort;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    modport slave (
        input  start, abort, a_data, b_data,
        output a_addr, b_addr, wr_en, wr_addr, wr_data, busy, done
    );

    modport master (
        output start, abort, a_data, b_data,
        input  a_addr, b_addr, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences C = A x B over NxN signed matrices with a single shared multiply-accumulate,
// reading operands from the register bank and writing each C element back in row-major order.
module matmul_sequencer #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 32,
    parameter int unsigned AW = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    matmul_sequencer_if.slave  bus
);
    localparam int unsigned    CW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  IDX_LAST = CW'(N - 1);
    localparam logic [AW-1:0]  N_AW   = AW'(N);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_ACC, S_WRITE, S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_i, r_j, r_k, w_i_nxt, w_j_nxt, w_k_nxt;
    logic [DW-1:0]   r_acc, w_acc_nxt, w_prod_lo;
    logic [AW-1:0]   r_a_addr, r_b_addr, r_wr_addr;
    logic [AW-1:0]   w_a_addr_nxt, w_b_addr_nxt, w_wr_addr_nxt;
    logic [DW-1:0]   r_wr_data, w_wr_data_nxt;
    logic            r_wr_en, r_busy, r_done;
    logic            w_wr_en_nxt, w_busy_nxt, w_done_nxt;

    // Low DW bits of the signed 2*DW product equal the truncated DW x DW product.
    assign w_prod_lo = bus.a_data * bus.b_data;

    function automatic logic [AW-1:0] f_idx(input logic [CW-1:0] row, input logic [CW-1:0] col);
        return AW'(row) * N_AW + AW'(col);
    endfunction

    // State register plus counters, accumulator and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_a_addr  <= '0;
            r_b_addr  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_i       <= w_i_nxt;
            r_j       <= w_j_nxt;
            r_k       <= w_k_nxt;
            r_acc     <= w_acc_nxt;
            r_a_addr  <= w_a_addr_nxt;
            r_b_addr  <= w_b_addr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state, loop indices and accumulator.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt = S_CLEAR;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                end
            end
            S_CLEAR: begin
                w_acc_nxt   = '0;
                w_k_nxt     = '0;
                w_state_nxt = S_FETCH;
            end
            S_FETCH: w_state_nxt = S_ACC;
            S_ACC: begin
                w_acc_nxt = r_acc + w_prod_lo;
                if (r_k == IDX_LAST) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_k_nxt     = r_k + CW'(1);
                    w_state_nxt = S_FETCH;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_CLEAR;
                if (r_j == IDX_LAST) begin
                    w_j_nxt = '0;
                    if (r_i == IDX_LAST) begin
                        w_i_nxt     = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_i_nxt = r_i + CW'(1);
                    end
                end else begin
                    w_j_nxt = r_j + CW'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Output values for the next cycle, derived from the next state so they align with it.
    always_comb begin
        w_a_addr_nxt  = r_a_addr;
        w_b_addr_nxt  = r_b_addr;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_wr_en_nxt   = (w_state_nxt == S_WRITE);
        w_busy_nxt    = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        w_done_nxt    = (w_state_nxt == S_DONE);
        if (w_state_nxt == S_FETCH) begin
            w_a_addr_nxt = f_idx(w_i_nxt, w_k_nxt);
            w_b_addr_nxt = f_idx(w_k_nxt, w_j_nxt);
        end
        if (w_state_nxt == S_WRITE) begin
            w_wr_addr_nxt = f_idx(w_i_nxt, w_j_nxt);
            w_wr_data_nxt = w_acc_nxt;
        end
    end

    assign bus.a_addr  = r_a_addr;
    assign bus.b_addr  = r_b_addr;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule
